rns_add_arbiter: RTL and testbench
==================================

Name: rns_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one three-channel RNS adder (`set3_add`) among NREQ requesters.
- Each requester presents an RNS operand pair with a valid/ready handshake.
- The block grants at most one request per cycle, registers the modular sum with the winner's ID, and holds it until the consumer accepts it.
- It sits between the DNN partial-sum producers and the accumulation stage.

Parameters:
- N, 11, base residue width. Channel 1 is N+1 bits mod 2^(N+1)-1. Channel 2 is N bits mod 2^N. Channel 3 is N bits mod 2^N-1.
- NREQ, 4, number of requesters (>=2).
- IDW, $clog2(NREQ), width of the requester ID.
- W, 3*N+1, derived packed residue-triple width. Not overridable.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept.
- req_a  input  NREQ*W  operand A of requester i at [i*W +: W].
- req_b  input  NREQ*W  operand B of requester i at [i*W +: W].
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  packed residue sum.
- out_id  output  IDW  index of the requester that produced out_sum.
- busy_cnt  output  16  saturating count of cycles with any req_valid high and no grant.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Packing: a triple is packed as [W-1:2N] = ch1, [2N-1:N] = ch2, [N-1:0] = ch3.
- Reset values: out_valid=0, out_sum=0, out_id=0, rr_ptr=0, busy_cnt=0. req_ready=0 while rst is high.
- Reset mid-operation: a held result is discarded and no handshake completes in the reset cycle.
- can_load = !out_valid || out_ready.
- Grant rule:
  - Search requesters in order rr_ptr, rr_ptr+1, … mod NREQ.
  - The first one with req_valid high is the winner, if can_load.
  - req_ready is one-hot on the winner and all zero otherwise.
  - req_ready is combinational from req_valid, rr_ptr and out_valid/out_ready.
- Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i].
  - A requester must hold req_valid, req_a and req_b stable until it is accepted.
  - Deasserting req_valid before acceptance is allowed. The request is simply not taken.
- Latency: a request accepted at edge k yields out_valid=1 with its sum and out_id after edge k.
  - out_sum/out_id stay stable while out_valid && !out_ready.
- Simultaneous drain and load: when out_valid && out_ready and a grant occurs in the same cycle, the new result replaces the old one. Throughput is 1 per cycle with no bubble.
- Drain with no grant: when out_ready is high and no grant occurs, out_valid falls to 0.
- Pointer update: rr_ptr = (winner+1) mod NREQ, only on an accepted grant. Otherwise it is unchanged. Wrap from NREQ-1 goes to 0.
- Arithmetic: bit-exact with set3_add.
  - ch2 is a plain N-bit add; the carry is dropped.
  - ch1 and ch3 are end-around-carry modular adds.
  - The all-ones pattern (second zero representation) is not normalised and passes through as produced.
  - Operands are assumed in range. All-ones inputs are legal.
- busy_cnt: increments on each cycle where |req_valid && no grant (backpressure). It saturates at 16'hFFFF and clears only on rst.

Decomposition:
- Shared package rns_pkg holds:
  - constants N_DEF=11 and NREQ_DEF=4;
  - the function computing W from N;
  - the field offsets for ch1/ch2/ch3.
- Sub-modules:
  - One instance of the existing set3_add, fed by the winner's muxed operands (combinational, before the output register).
  - One natural sub-module, rr_arbiter, holding rr_ptr, the priority search, one-hot grant and winner index.

Test Plan:
- Reset mid-hold: set out_valid=1 with out_ready=0, then pulse rst for 1 cycle -> next cycle out_valid=0, rr_ptr=0, req_ready=0 during rst.
- Single request, N=11: requester 2 sends A={ch1=4000, ch2=2000, ch3=2000}, B={200, 100, 100} -> one cycle later out_sum={105, 52, 53}, out_id=2.
- Fairness: all four valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,1, one grant per cycle, no bubbles.
- Backpressure: all four valid, out_ready=0 for 5 cycles after the first accept -> req_ready all 0, out_sum/out_id stable, busy_cnt=5. Raising out_ready -> next grant goes to id 1.
- Sparse and wrap: only requesters 3 and 1 valid, rr_ptr=2 -> grant 3, then rr_ptr=0, then grant 1.
- Boundary arithmetic: ch3 operands 2046+1 -> 2047 (all-ones, unnormalised). ch1 operands 4095+4095 -> 4095. ch2 operands 2047+1 -> 0.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared constants and helpers for the RNS adder and its arbiter.
//   N_DEF / NREQ_DEF : default base residue width and requester count
//   calc_w()         : packed residue-triple width for a given N
//   ch*_lo()         : LSB offset of each channel inside a packed triple
// Packing: [W-1:2N] = ch1 (mod 2^(N+1)-1), [2N-1:N] = ch2 (mod 2^N),
//          [N-1:0] = ch3 (mod 2^N-1)
package rns_pkg;

   localparam int N_DEF    = 11;
   localparam int NREQ_DEF = 4;

   function automatic int calc_w(input int n);
      return 3 * n + 1;
   endfunction

   function automatic int ch1_lo(input int n);
      return 2 * n;
   endfunction

   function automatic int ch2_lo(input int n);
      return n;
   endfunction

   function automatic int ch3_lo(input int n);
      return 0 * n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with pointer register.
//   clk, rst : clock, synchronous active-high reset
//   en       : grant permitted this cycle (result slot can load)
//   req      : per-requester valid
//   grant    : one-hot grant (all zero when no winner)
//   winner   : index of granted requester
//   granted  : a grant is issued this cycle
// Search starts at rr_ptr; the pointer moves past the winner on grant.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int          IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  winner,
   output logic            granted
);

   logic [IDW-1:0] rr_ptr;
   int unsigned    idx;

   always_comb begin
      grant   = '0;
      winner  = '0;
      granted = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!granted && en && req[idx]) begin
            granted    = 1'b1;
            grant[idx] = 1'b1;
            winner     = IDW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (granted) begin
         rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end
   end

endmodule

// File: rtl/set3_add.sv
// Three-channel RNS adder, purely combinational.
//   a, b : packed operand triples (W = 3N+1 bits)
//   sum  : packed residue sum
// ch1 and ch3 use end-around carry; ch2 drops the carry. The all-ones
// second zero representation is passed through unnormalised.
module set3_add
   import rns_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [3*N:0] a,
   input  logic [3*N:0] b,
   output logic [3*N:0] sum
);

   localparam int C1 = ch1_lo(N);
   localparam int C2 = ch2_lo(N);
   localparam int C3 = ch3_lo(N);

   logic [N+1:0] s1;
   logic [N:0]   s3;
   logic [N:0]   r1;
   logic [N-1:0] r2;
   logic [N-1:0] r3;

   // Operands in range keep the folded carry from overflowing a second time.
   always_comb begin
      s1 = {1'b0, a[C1 +: N+1]} + {1'b0, b[C1 +: N+1]};
      r1 = s1[N:0] + {{N{1'b0}}, s1[N+1]};
      r2 = a[C2 +: N] + b[C2 +: N];
      s3 = {1'b0, a[C3 +: N]} + {1'b0, b[C3 +: N]};
      r3 = s3[N-1:0] + {{(N-1){1'b0}}, s3[N]};
      sum = {r1, r2, r3};
   end

endmodule

// File: rtl/rns_add_arbiter.sv
// Shares one set3_add among NREQ requesters with round-robin arbitration.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester operand valid
//   req_ready : one-hot accept for the winning requester
//   req_a/b   : operand triples, requester i at [i*W +: W]
//   out_valid : result register holds data
//   out_ready : consumer accepts result
//   out_sum   : packed residue sum
//   out_id    : requester that produced out_sum
//   busy_cnt  : saturating count of cycles with pending requests and no grant
module rns_add_arbiter
   import rns_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*(3*N+1)-1:0]  req_a,
   input  logic [NREQ*(3*N+1)-1:0]  req_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3*N:0]             out_sum,
   output logic [IDW-1:0]           out_id,
   output logic [15:0]              busy_cnt
);

   localparam int W = calc_w(N);

   logic           can_load;
   logic           granted;
   logic [IDW-1:0] winner;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;
   logic [W-1:0]   sum_comb;

   // Gating with !rst keeps req_ready low and blocks any handshake in reset.
   assign can_load = (!out_valid || out_ready) && !rst;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .en      (can_load),
      .req     (req_valid),
      .grant   (req_ready),
      .winner  (winner),
      .granted (granted)
   );

   always_comb begin
      a_sel = req_a[int'(winner)*W +: W];
      b_sel = req_b[int'(winner)*W +: W];
   end

   set3_add #(
      .N (N)
   ) u_add (
      .a   (a_sel),
      .b   (b_sel),
      .sum (sum_comb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_id    <= '0;
      end else if (granted) begin
         out_valid <= 1'b1;
         out_sum   <= sum_comb;
         out_id    <= winner;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cnt <= '0;
      end else if ((|req_valid) && !granted && (busy_cnt != 16'hFFFF)) begin
         busy_cnt <= busy_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_rns_add_arbiter.sv
module tb_rns_add_arbiter;

   localparam int N    = 11;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int W    = 3 * N + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W-1:0]    req_a;
   logic [NREQ*W-1:0]    req_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [W-1:0]         out_sum;
   logic [IDW-1:0]       out_id;
   logic [15:0]          busy_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rns_add_arbiter #(
      .N    (N),
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_id    (out_id),
      .busy_cnt  (busy_cnt)
   );

   function automatic logic [W-1:0] pack(input int c1, input int c2, input int c3);
      logic [N:0]   f1;
      logic [N-1:0] f2;
      logic [N-1:0] f3;
      f1 = (N+1)'(c1);
      f2 = N'(c2);
      f3 = N'(c3);
      return {f1, f2, f3};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   logic [W-1:0] held_sum;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      out_ready = 1'b0;
      tick();
      tick();

      // reset state
      req_valid = 4'b1111;
      #1;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_sum",   64'(out_sum),   64'h0);
      check("rst_id",    64'(out_id),    64'h0);
      check("rst_busy",  64'(busy_cnt),  64'h0);
      req_valid = '0;
      rst = 1'b0;
      #1;

      // single request from requester 2
      set_req(2, pack(4000, 2000, 2000), pack(200, 100, 100));
      req_valid = 4'b0100;
      #1;
      check("single_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      check("single_valid", 64'(out_valid), 64'h1);
      check("single_sum",   64'(out_sum),   64'(pack(105, 52, 53)));
      check("single_id",    64'(out_id),    64'h2);
      tick();
      tick();
      check("hold_valid", 64'(out_valid), 64'h1);
      check("hold_sum",   64'(out_sum),   64'(pack(105, 52, 53)));

      // reset while holding: result dropped, pointer back to 0
      req_valid = 4'b1111;
      rst = 1'b1;
      #1;
      check("midrst_ready", 64'(req_ready), 64'h0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'h0);
      check("midrst_busy",  64'(busy_cnt),  64'h0);
      check("midrst_ptr",   64'(req_ready), 64'h1);

      // fairness with continuous drain
      for (int i = 0; i < NREQ; i++) set_req(i, pack(i, i, i), pack(1, 1, 1));
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("fair_ready%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
         tick();
         check($sformatf("fair_valid%0d", k), 64'(out_valid), 64'h1);
         check($sformatf("fair_id%0d", k),    64'(out_id),    64'(k % 4));
         check($sformatf("fair_sum%0d", k),   64'(out_sum),
               64'(pack(k % 4 + 1, k % 4 + 1, k % 4 + 1)));
      end
      req_valid = '0;
      tick();
      check("drain_valid", 64'(out_valid), 64'h0);
      check("fair_busy",   64'(busy_cnt),  64'h0);

      // backpressure
      pulse_reset();
      out_ready = 1'b0;
      req_valid = 4'b1111;
      tick();
      check("bp_first_id", 64'(out_id), 64'h0);
      held_sum = out_sum;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_ready%0d", k), 64'(req_ready), 64'h0);
         tick();
         check($sformatf("bp_id%0d", k),  64'(out_id),  64'h0);
         check($sformatf("bp_sum%0d", k), 64'(out_sum), 64'(held_sum));
      end
      check("bp_busy", 64'(busy_cnt), 64'd5);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(req_ready), 64'h2);
      tick();
      check("bp_release_id", 64'(out_id),   64'h1);
      check("bp_busy_after", 64'(busy_cnt), 64'd5);

      // sparse requests and pointer wrap
      pulse_reset();
      out_ready = 1'b1;
      req_valid = 4'b0010;
      tick();
      check("sp_first_id", 64'(out_id), 64'h1);
      req_valid = 4'b1010;
      #1;
      check("sp_ready3", 64'(req_ready), 64'h8);
      tick();
      check("sp_id3", 64'(out_id), 64'h3);
      check("sp_ready1", 64'(req_ready), 64'h2);
      tick();
      check("sp_id1", 64'(out_id), 64'h1);
      req_valid = '0;
      tick();

      // boundary arithmetic
      set_req(0, pack(4095, 2047, 2046), pack(4095, 1, 1));
      req_valid = 4'b0001;
      #1;
      check("bnd_ready", 64'(req_ready), 64'h1);
      tick();
      check("bnd_sum0", 64'(out_sum), 64'(pack(4095, 0, 2047)));
      set_req(0, pack(4094, 1000, 2047), pack(1, 1048, 2047));
      tick();
      check("bnd_sum1", 64'(out_sum), 64'(pack(4095, 0, 2047)));
      set_req(0, pack(0, 0, 0), pack(4095, 2047, 2047));
      tick();
      check("bnd_sum2", 64'(out_sum), 64'(pack(4095, 2047, 2047)));
      req_valid = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
